// File: rtl/c432_irq_ctrl.sv
// ---------------------------------------------------------------------------
// c432_irq_ctrl
//   Registered 27-channel priority interrupt controller. It is functionally
//   the ISCAS-85 c432 with a register stage on the outputs.
//
//   There are three 9-channel request buses: A, B and C. A 9-bit enable
//   vector masks channel i on all three buses at the same time.
//
//   Bus priority is A > B > C. Within the winning bus, the highest channel
//   index wins.
//
//   Every cycle is independent. The only state is the output register, so
//   the result appears one cycle after the inputs are sampled.
//
// Ports
//   clk         rising-edge clock for all flops
//   rst         synchronous, active-high reset; clears all outputs
//   in1..in9    E[8:0] channel enables   (in1 = E[8] ... in9  = E[0])
//   in10..in18  A[8:0] bus A requests    (in10 = A[8] ... in18 = A[0])
//   in19..in27  B[8:0] bus B requests    (in19 = B[8] ... in27 = B[0])
//   in28..in36  C[8:0] bus C requests    (in28 = C[8] ... in36 = C[0])
//   out1        PA: bus A won
//   out2        PB: bus B won
//   out3        PC: bus C won
//   out4..out7  Chan[3:0] winning channel (out4 = Chan[3] ... out7 = Chan[0])
//
// Outputs are all zero when no enabled request is present.
// ---------------------------------------------------------------------------
module c432_irq_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic in1,  input logic in2,  input logic in3,
  input  logic in4,  input logic in5,  input logic in6,
  input  logic in7,  input logic in8,  input logic in9,
  input  logic in10, input logic in11, input logic in12,
  input  logic in13, input logic in14, input logic in15,
  input  logic in16, input logic in17, input logic in18,
  input  logic in19, input logic in20, input logic in21,
  input  logic in22, input logic in23, input logic in24,
  input  logic in25, input logic in26, input logic in27,
  input  logic in28, input logic in29, input logic in30,
  input  logic in31, input logic in32, input logic in33,
  input  logic in34, input logic in35, input logic in36,
  output logic out1,
  output logic out2,
  output logic out3,
  output logic out4,
  output logic out5,
  output logic out6,
  output logic out7
);

  // Pin-to-vector mapping: the lowest-numbered pin of each group is bit 8.
  logic [8:0] en;
  logic [8:0] req_a;
  logic [8:0] req_b;
  logic [8:0] req_c;

  assign en    = {in1,  in2,  in3,  in4,  in5,  in6,  in7,  in8,  in9};
  assign req_a = {in10, in11, in12, in13, in14, in15, in16, in17, in18};
  assign req_b = {in19, in20, in21, in22, in23, in24, in25, in26, in27};
  assign req_c = {in28, in29, in30, in31, in32, in33, in34, in35, in36};

  // Masked requests, bus flags and winning-bus vector.
  logic [8:0] act_a;
  logic [8:0] act_b;
  logic [8:0] act_c;
  logic [8:0] win;
  logic       pa_d;
  logic       pb_d;
  logic       pc_d;
  logic [3:0] chan_d;

  always_comb begin
    act_a = req_a & en;
    act_b = req_b & en;
    act_c = req_c & en;

    // The bus flags are mutually exclusive by construction.
    pa_d = |act_a;
    pb_d = ~pa_d & (|act_b);
    pc_d = ~pa_d & ~pb_d & (|act_c);

    if (pa_d)      win = act_a;
    else if (pb_d) win = act_b;
    else if (pc_d) win = act_c;
    else           win = '0;

    // Priority encoder. The scan runs upward, so a higher set bit
    // overwrites a lower one and the highest index wins. When win is
    // zero, the index stays at 0.
    chan_d = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (win[i]) chan_d = 4'(i);
    end
  end

  // Output register. Reset overrides any request sampled on the same edge.
  logic       pa_q;
  logic       pb_q;
  logic       pc_q;
  logic [3:0] chan_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pa_q   <= 1'b0;
      pb_q   <= 1'b0;
      pc_q   <= 1'b0;
      chan_q <= 4'd0;
    end else begin
      pa_q   <= pa_d;
      pb_q   <= pb_d;
      pc_q   <= pc_d;
      chan_q <= chan_d;
    end
  end

  assign out1 = pa_q;
  assign out2 = pb_q;
  assign out3 = pc_q;
  assign out4 = chan_q[3];
  assign out5 = chan_q[2];
  assign out6 = chan_q[1];
  assign out7 = chan_q[0];

endmodule

// File: tb/tb_c432_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_c432_irq_ctrl
//   Self-checking bench for c432_irq_ctrl.
//
//   Checked results are packed as {PA, PB, PC, Chan[3:0]}, which is the same
//   order as out1..out7.
//
//   Stimulus comes from three sources:
//     - a table of hand-derived vectors;
//     - hand-written sequences for reset and mid-cycle input changes;
//     - random vectors checked against a reference model.
//
//   The model picks the first non-empty masked bus in A, B, C order. It then
//   takes floor(log2) of that bus word as the channel index.
// ---------------------------------------------------------------------------
module tb_c432_irq_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [8:0] e_v = '0;
  logic [8:0] a_v = '0;
  logic [8:0] b_v = '0;
  logic [8:0] c_v = '0;

  logic out1, out2, out3, out4, out5, out6, out7;
  logic [6:0] act;
  assign act = {out1, out2, out3, out4, out5, out6, out7};

  c432_irq_ctrl dut (
    .clk(clk), .rst(rst),
    .in1(e_v[8]),  .in2(e_v[7]),  .in3(e_v[6]),  .in4(e_v[5]),  .in5(e_v[4]),
    .in6(e_v[3]),  .in7(e_v[2]),  .in8(e_v[1]),  .in9(e_v[0]),
    .in10(a_v[8]), .in11(a_v[7]), .in12(a_v[6]), .in13(a_v[5]), .in14(a_v[4]),
    .in15(a_v[3]), .in16(a_v[2]), .in17(a_v[1]), .in18(a_v[0]),
    .in19(b_v[8]), .in20(b_v[7]), .in21(b_v[6]), .in22(b_v[5]), .in23(b_v[4]),
    .in24(b_v[3]), .in25(b_v[2]), .in26(b_v[1]), .in27(b_v[0]),
    .in28(c_v[8]), .in29(c_v[7]), .in30(c_v[6]), .in31(c_v[5]), .in32(c_v[4]),
    .in33(c_v[3]), .in34(c_v[2]), .in35(c_v[1]), .in36(c_v[0]),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .out5(out5), .out6(out6), .out7(out7)
  );

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Pops the next expected value and compares it with the sampled outputs.
  task automatic check_next(input string name);
    logic [6:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: expected queue empty, actual=%b", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: actual=%b required=%b", name, act, exp);
      end
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] ref_model(input logic [8:0] e, input logic [8:0] a,
                                           input logic [8:0] b, input logic [8:0] c);
    logic [8:0] words[3];
    int unsigned w;
    words[0] = a & e;
    words[1] = b & e;
    words[2] = c & e;
    for (int k = 0; k < 3; k++) begin
      if (words[k] != 0) begin
        w = words[k];
        // floor(log2(w)) is the index of the highest set bit.
        return {3'b100 >> k, 4'($clog2(w + 1) - 1)};
      end
    end
    return 7'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [8:0] e, input logic [8:0] a,
                       input logic [8:0] b, input logic [8:0] c);
    e_v = e; a_v = a; b_v = b; c_v = c;
  endtask

  // Advance past one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic [8:0] e, a, b, c;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"enables_only",   9'h1FF, 9'h000, 9'h000, 9'h000, 7'b000_0000};
    vecs[1]  = '{"a8",             9'h1FF, 9'h100, 9'h000, 9'h000, 7'b100_1000};
    vecs[2]  = '{"a8_b7_prio",     9'h1FF, 9'h100, 9'h080, 9'h000, 7'b100_1000};
    vecs[3]  = '{"b7",             9'h1FF, 9'h000, 9'h080, 9'h000, 7'b010_0111};
    vecs[4]  = '{"mask_c3",        9'h008, 9'h100, 9'h000, 9'h008, 7'b001_0011};
    vecs[5]  = '{"all_ones",       9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'b100_1000};
    vecs[6]  = '{"c0",             9'h1FF, 9'h000, 9'h000, 9'h001, 7'b001_0000};
    vecs[7]  = '{"b_masked_c1",    9'h0FE, 9'h000, 9'h001, 9'h002, 7'b001_0001};
    vecs[8]  = '{"a0_beats_b8",    9'h1FF, 9'h001, 9'h100, 9'h000, 7'b100_0000};
    vecs[9]  = '{"all_masked",     9'h000, 9'h1FF, 9'h1FF, 9'h1FF, 7'b000_0000};
    vecs[10] = '{"b_high_1aa",     9'h1FF, 9'h000, 9'h1AA, 9'h1FF, 7'b010_1000};
    vecs[11] = '{"a_masked_c6",    9'h055, 9'h0AA, 9'h000, 9'h0F0, 7'b001_0110};

    // 1. Reset and idle.
    drive('0, '0, '0, '0);
    rst = 1'b1;
    step();
    exp_q.push_back(7'd0); check_next("reset_hold");
    rst = 1'b0;
    step();
    exp_q.push_back(7'd0); check_next("idle_after_reset");

    // Table vectors: drive, wait one edge, compare.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].e, vecs[i].a, vecs[i].b, vecs[i].c);
      step();
      exp_q.push_back(vecs[i].exp);
      check_next(vecs[i].name);
    end

    // Reset mid-run while all-ones is held. Reset wins at that edge; the
    // result returns one cycle after release.
    drive('1, '1, '1, '1);
    step();
    exp_q.push_back(7'b100_1000); check_next("ones_before_rst");
    rst = 1'b1;
    step();
    exp_q.push_back(7'd0); check_next("rst_overrides_req");
    rst = 1'b0;
    step();
    exp_q.push_back(7'b100_1000); check_next("ones_after_rst");

    // Inputs that change between edges have no effect until the next edge.
    drive(9'h1FF, 9'h000, 9'h010, 9'h000);
    step();
    exp_q.push_back(7'b010_0100); check_next("b4_sampled");
    @(negedge clk);
    drive(9'h1FF, 9'h000, 9'h000, 9'h004);
    #1;
    exp_q.push_back(7'b010_0100); check_next("midcycle_hold");
    step();
    exp_q.push_back(7'b001_0010); check_next("c2_after_edge");

    // Random stimulus against the model, with occasional reset.
    for (int n = 0; n < 400; n++) begin
      logic [8:0] e, a, b, c;
      logic       r;
      e = 9'($urandom_range(0, 511));
      a = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'd0;
      b = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 511)) : 9'd0;
      c = 9'($urandom_range(0, 511));
      r = ($urandom_range(0, 19) == 0);
      drive(e, a, b, c);
      rst = r;
      step();
      exp_q.push_back(r ? 7'd0 : ref_model(e, a, b, c));
      check_next("random");
    end
    rst = 1'b0;

    // ---------------- final report ----------------
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: actual=%0d entries required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
